multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 13 +
 rtl/multiplier_datapath.sv | 48 ++++
 rtl/multiplier.sv | 84 ++++++++
 tb/tb_multiplier.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the control state encoding and the default operand width.
package multiplier_pkg;

  localparam int IN_SIZE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multiplier_pkg

// File: rtl/multiplier_datapath.sv
// Shift-and-add datapath: operand shift registers, accumulator and bit counter.
// The multiplicand is kept double width so it can be shifted left without loss.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int inSize = IN_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [inSize-1:0]     op_a,
  input  logic [inSize-1:0]     op_b,
  output logic [2*inSize-1:0]   acc,
  output logic                  last
);

  localparam int CNT_W = $clog2(inSize);

  logic [2*inSize-1:0] mcand;
  logic [inSize-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{inSize{1'b0}}, op_a};
      mplier <= op_b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Asserted during the final BUSY cycle, i.e. the one consuming the multiplier MSB.
  assign last = (cnt == CNT_W'(inSize - 1));

endmodule : multiplier_datapath

// File: rtl/multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, result registered.
//   state | meaning
//   IDLE  | waiting for en; captures operands on start
//   BUSY  | one shift-and-add step per cycle, inSize cycles
//   DONE  | accumulator complete; sum/valid load on the way back to IDLE
module multiplier
  import multiplier_pkg::*;
#(
  parameter int inSize = IN_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [inSize-1:0]     A,
  input  logic [inSize-1:0]     B,
  output logic [2*inSize-1:0]   sum,
  output logic                  valid
);

  state_t              state_q;
  state_t              state_d;
  logic                load;
  logic                step;
  logic                done;
  logic                last;
  logic [2*inSize-1:0] acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = en ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE:    load = en;
      BUSY:    step = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // sum holds the previous result until the next DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        sum <= acc;
      end
    end
  end

  multiplier_datapath #(
    .inSize(inSize)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .op_a (A),
    .op_b (B),
    .acc  (acc),
    .last (last)
  );

endmodule : multiplier

// File: tb/tb_multiplier.sv
// Directed bench for the 4-bit sequential multiplier: latency, throughput,
// operand isolation during BUSY, zero operands and synchronous reset abort.
module tb_multiplier;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] sum;
  logic       valid;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_sum = 8'd0;

  multiplier #(.inSize(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A     (A),
    .B     (B),
    .sum   (sum),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after
  // the cycle following the valid pulse, with the DUT idle again.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input bit mess);
    A  = a;
    B  = b;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (mess) begin
      A  = 4'd7;
      B  = 4'd9;
      en = 1'b1;
    end else begin
      en = 1'b0;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 5) begin
        chk({tag, "_busy_valid"}, valid, 1'b0);
        if (k == 4) chk({tag, "_hold_sum"}, sum, prev_sum);
        if (mess && k == 4) en = 1'b0;
      end else if (k == 5) begin
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_sum"}, sum, exp);
      end else begin
        chk({tag, "_pulse_end"}, valid, 1'b0);
        chk({tag, "_sum_held"}, sum, exp);
      end
    end
    prev_sum = exp;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    A   = 4'd0;
    B   = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sum", sum, 8'd0);
    chk("reset_valid", valid, 1'b0);
    rst = 1'b1;

    // en low: nothing ever happens
    A = 4'd5;
    B = 4'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_valid", valid, 1'b0);
    end
    chk("idle_sum", sum, 8'd0);

    // 1*2 with en held: valid 5 edges after start, then every 6 edges
    A  = 4'd1;
    B  = 4'd2;
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 17) en = 1'b0;
      chk("stream_valid", valid, (k % 6 == 5) ? 1'b1 : 1'b0);
      chk("stream_sum", sum, (k >= 5) ? 8'd2 : 8'd0);
    end
    prev_sum = 8'd2;

    do_op("max", 4'd15, 4'd15, 8'hE1, 1'b0);
    do_op("zero_a", 4'd0, 4'd13, 8'd0, 1'b0);
    do_op("mixed", 4'd13, 4'd11, 8'd143, 1'b0);
    do_op("zero_b", 4'd9, 4'd0, 8'd0, 1'b0);
    do_op("b_one", 4'd15, 4'd1, 8'd15, 1'b0);
    do_op("msb_only", 4'd8, 4'd15, 8'd120, 1'b0);
    do_op("ignore_chg", 4'd3, 4'd5, 8'd15, 1'b0 | 1'b1);

    // reset while BUSY aborts without a valid pulse
    A  = 4'd5;
    B  = 4'd6;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sum", sum, 8'd0);
    chk("abort_valid", valid, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_pulse", valid, 1'b0);
    end
    chk("abort_sum_held", sum, 8'd0);
    prev_sum = 8'd0;

    do_op("after_abort", 4'd6, 4'd7, 8'd42, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiplier
